count_display_driver: RTL and testbench
=======================================

// Module: count_display_driver
// PURPOSE
//  Consumes the 8-bit free-running count produced by the tick-driven counter.
//  Converts the count to BCD with an iterative double-dabble FSM.
//  Drives a 4-digit multiplexed 7-segment display, using 3 digits, with
//  leading-zero blanking.
//  Sits between the counter's count[7:0] output and the board display pins.
// PARAMETERS
//  SCAN_DIV    50000  clk cycles each digit is lit (1 kHz/digit at 50 MHz); must be >=2
//  ACTIVE_LOW  1      1: an/seg active-low (common-anode); 0: active-high
// PORTS
//  clk    in   1   system clock
//  reset  in   1   synchronous, active-high
//  value  in   8   binary count to display, sampled every cycle
//  seg    out  7   segments {g,f,e,d,c,b,a}; seg[0]=a
//  dp     out  1   decimal point, always driven inactive
//  an     out  4   digit enables; an[0]=ones, an[1]=tens, an[2]=hundreds, an[3]=unused
//  bcd    out  12  last converted value {hundreds,tens,ones}
//  busy   out  1   high while a conversion is in progress
// BEHAVIOUR
//  Reset (clk edge with reset=1) forces all of the following:
//   - shadow=0, bcd=0, busy=0, FSM=IDLE
//   - scan counter=0, digit index=0
//   - an = all inactive; seg = all off; dp inactive
//   - Applies at any point, including mid-conversion; the partial result is discarded.
//  Conversion FSM (IDLE -> SHIFT -> DONE -> IDLE):
//   - IDLE: if value != shadow, then shadow<=value, load shift reg {12'h000,value},
//     iter<=0, busy<=1, go to SHIFT. Otherwise stay.
//   - SHIFT: each cycle, add 3 to every BCD nibble >=5, then shift left 1; iter++.
//     After the 8th shift, go to DONE.
//   - DONE: bcd<=result, busy<=0, go to IDLE.
//   - Latency: value change seen at edge N -> busy high from N+1 -> bcd updated at
//     edge N+10. busy is high for exactly 9 cycles.
//   - value changes while busy are ignored. Re-compare in IDLE guarantees the final
//     settled value is always converted. Intermediate values may be skipped.
//   - Constant value after reset (including 0): no conversion; bcd stays 0.
//  Scan multiplexer:
//   - scan counter counts 0..SCAN_DIV-1 and wraps.
//   - On wrap, digit index advances 0->1->2->3->0.
//   - an/seg are registered: they reflect the new digit index one cycle after it changes.
//   - Exactly one an bit is active, or none; never two.
//   - Digit 3 is always blank: all an inactive for that slot.
//   - Hundreds blank when hundreds==0.
//   - Tens blank when hundreds==0 and tens==0.
//   - Ones is never blank.
//   - A blank slot drives all an inactive and seg all off.
//   - Display reads bcd directly; a bcd update mid-slot shows at the next cycle.
//  Segment decode (active-high, {g..a}):
//   - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; nibble>9 -> 00.
//   - When ACTIVE_LOW=1, both seg and an are inverted.
// TESTING (ACTIVE_LOW=1, SCAN_DIV=4)
//  1. Hold reset 3 cycles -> an=4'b1111, seg=7'h7F, bcd=12'h000, busy=0.
//     Release with value=0 -> ones slot: an=4'b1110, seg=7'h40; other slots: an=4'b1111.
//  2. value 0->255 at edge N -> busy=1 for edges N+1..N+9; bcd=12'h255 at N+10.
//     Slots show 5 (seg 7'h12), 5 (7'h12), 2 (7'h24) on an 1110/1101/1011.
//  3. value=7 -> bcd=12'h007; only an=4'b1110 ever active, seg=7'h78.
//     Tens and hundreds slots: an=4'b1111.
//  4. value=100, then value=200 two cycles later -> bcd=12'h100 at +10,
//     then a second conversion -> bcd=12'h200. Final display "200", tens zero shown.
//  5. value=255, reset asserted 4 cycles into SHIFT -> busy=0, bcd=12'h000.
//     After release, 255 is reconverted; bcd=12'h255 ten cycles later.
//  6. Run 64 cycles with fixed value -> digit slots rotate every 4 cycles.
//     an never has more than one bit low; the an[3] slot is always 1111.

Source files
------------

// File: rtl/count_display_driver.sv
// Binary count -> BCD (iterative double-dabble) -> 3-digit multiplexed 7-segment display.
// Leading zeros are blanked; the fourth digit slot is always dark.
module count_display_driver #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  value,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  shadow;
  logic [19:0] sr;
  logic [2:0]  iter;

  // One double-dabble step: correct each BCD nibble, then shift in the next binary bit.
  function automatic logic [19:0] dd_step(input logic [19:0] s);
    logic [19:0] t;
    t = s;
    for (int i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (value != shadow) state_next = SHIFT;
      SHIFT:   if (iter == 3'd7)    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= '0;
      sr     <= '0;
      iter   <= '0;
      bcd    <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (value != shadow) begin
          shadow <= value;
          sr     <= {12'h000, value};
          iter   <= '0;
          busy   <= 1'b1;
        end
        SHIFT: begin
          sr   <= dd_step(sr);
          iter <= iter + 3'd1;
        end
        DONE: begin
          bcd  <= sr[19:8];
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Scan timing: each digit slot is held for SCAN_DIV cycles.
  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        dig;

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      dig      <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      dig      <= dig + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  logic [3:0] nib;
  logic       blank;
  logic [3:0] an_act;
  logic [6:0] seg_act;

  always_comb begin
    nib   = bcd[3:0];
    blank = 1'b0;
    case (dig)
      2'd0: begin nib = bcd[3:0];  blank = 1'b0; end
      2'd1: begin nib = bcd[7:4];  blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0); end
      2'd2: begin nib = bcd[11:8]; blank = (bcd[11:8] == 4'd0); end
      default: begin nib = 4'd0;   blank = 1'b1; end
    endcase
    an_act  = blank ? 4'h0 : (4'b0001 << dig);
    seg_act = blank ? 7'h00 : seg_decode(nib);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
    end else begin
      an  <= ACTIVE_LOW ? ~an_act  : an_act;
      seg <= ACTIVE_LOW ? ~seg_act : seg_act;
    end
  end

  assign dp = ACTIVE_LOW;

endmodule

// File: tb/tb_count_display_driver.sv
// Bench for count_display_driver: vector table of values with expected BCD, a
// scoreboard queue popped when busy falls, and display slot/rotation checks.
module tb_count_display_driver;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  value = 8'd0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [11:0] bcd;
  logic        busy;

  count_display_driver #(.SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .value(value), .seg(seg), .dp(dp),
    .an(an), .bcd(bcd), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [11:0] sbq[$];
  logic busy_q = 1'b0;

  typedef struct {
    logic [7:0]  v;
    logic [11:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Active-low segment pattern for a decimal digit.
  function automatic logic [6:0] seg_lo(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h3F; 4'd1: s = 7'h06; 4'd2: s = 7'h5B; 4'd3: s = 7'h4F;
      4'd4: s = 7'h66; 4'd5: s = 7'h6D; 4'd6: s = 7'h7D; 4'd7: s = 7'h07;
      4'd8: s = 7'h7F; 4'd9: s = 7'h6F; default: s = 7'h00;
    endcase
    return ~s;
  endfunction

  // Scoreboard: a completed conversion is the falling edge of busy outside reset.
  always @(negedge clk) begin
    if (busy_q === 1'b1 && busy === 1'b0 && reset === 1'b0) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: conversion produced bcd=%0h with nothing queued", bcd);
      end else begin
        chk("sb_bcd", 32'(bcd), 32'(sbq.pop_front()));
      end
    end
    busy_q <= busy;
  end

  task automatic wait_conv(input bit expect_conv);
    int n;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 30) begin
      n++;
      @(negedge clk);
    end
    if (expect_conv) chk("busy_cycles", n, 9);
    else             chk("no_conv", n, 0);
  endtask

  task automatic run_vec(input vec_t t, input logic [7:0] last);
    @(negedge clk);
    value = t.v;
    if (t.v != last) sbq.push_back(t.exp);
    wait_conv(t.v != last);
  endtask

  task automatic check_display(input logic [11:0] exp);
    int c0, c1, c2, coff;
    bit show_t, show_h;
    c0 = 0; c1 = 0; c2 = 0; coff = 0;
    show_h = (exp[11:8] != 4'd0);
    show_t = show_h || (exp[7:4] != 4'd0);
    repeat (16) begin
      @(negedge clk);
      case (an)
        4'b1110: begin c0++; chk("seg_ones", 32'(seg), 32'(seg_lo(exp[3:0]))); end
        4'b1101: begin c1++; chk("seg_tens", 32'(seg), 32'(seg_lo(exp[7:4]))); end
        4'b1011: begin c2++; chk("seg_hund", 32'(seg), 32'(seg_lo(exp[11:8]))); end
        4'b1111: begin coff++; chk("seg_blank", 32'(seg), 32'h7F); end
        default: chk("an_pattern", 32'(an), 32'hF);
      endcase
    end
    chk("cnt_ones", c0, 4);
    chk("cnt_tens", c1, show_t ? 4 : 0);
    chk("cnt_hund", c2, show_h ? 4 : 0);
  endtask

  function automatic logic [3:0] next_an(input logic [3:0] a);
    case (a)
      4'b1110: return 4'b1101;
      4'b1101: return 4'b1011;
      4'b1011: return 4'b1111;
      default: return 4'b1110;
    endcase
  endfunction

  initial begin
    vec_t tbl[8];
    logic [7:0] last;
    logic [3:0] prev;
    int run;
    bit first;

    tbl[0] = '{8'd255, 12'h255};
    tbl[1] = '{8'd7,   12'h007};
    tbl[2] = '{8'd0,   12'h000};
    tbl[3] = '{8'd10,  12'h010};
    tbl[4] = '{8'd99,  12'h099};
    tbl[5] = '{8'd128, 12'h128};
    tbl[6] = '{8'd9,   12'h009};
    tbl[7] = '{8'd201, 12'h201};

    // Reset state
    reset = 1'b1;
    value = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_bcd", 32'(bcd), 32'h000);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_dp", 32'(dp), 32'h1);
    reset = 1'b0;
    check_display(12'h000);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_bcd", 32'(bcd), 32'h000);
    last = 8'd0;

    // Table-driven conversions with display verification
    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i], last);
      last = tbl[i].v;
      chk("vec_bcd", 32'(bcd), 32'(tbl[i].exp));
      check_display(tbl[i].exp);
    end

    // Change ignored while busy; the settled value is reconverted afterwards
    @(negedge clk);
    value = 8'd100;
    sbq.push_back(12'h100);
    repeat (2) @(negedge clk);
    value = 8'd200;
    sbq.push_back(12'h200);
    repeat (30) @(negedge clk);
    chk("q_empty_200", sbq.size(), 0);
    chk("bcd_200", 32'(bcd), 32'h200);
    check_display(12'h200);

    // Reset mid-conversion discards the partial result
    @(negedge clk);
    value = 8'd255;
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_bcd", 32'(bcd), 32'h000);
    chk("abort_an", 32'(an), 32'hF);
    @(negedge clk);
    reset = 1'b0;
    sbq.push_back(12'h255);
    wait_conv(1'b1);
    chk("reconv_bcd", 32'(bcd), 32'h255);

    // Slot rotation over 64 cycles
    @(negedge clk);
    prev = an;
    run = 1;
    first = 1'b1;
    repeat (64) begin
      @(negedge clk);
      chk("an_onehot", 32'($countones(~an) <= 1), 32'h1);
      if (an !== prev) begin
        if (!first) chk("run_len", run, SCAN_DIV);
        chk("an_order", 32'(an), 32'(next_an(prev)));
        first = 1'b0;
        run = 1;
        prev = an;
      end else begin
        run++;
      end
    end
    chk("q_empty_end", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
